// File: rtl/dmg_timer.sv
// DMG timer/divider block (FF04-FF07): free-running 16-bit divider, DIV/TIMA/TMA/TAC
// registers, delayed TMA reload after TIMA overflow and a one-clock timer interrupt pulse.
module dmg_timer #(
    parameter int unsigned RELOAD_DELAY = 4
) (
    input  logic       clk,
    input  logic       res,
    input  logic [1:0] addr,
    input  logic       sel,
    input  logic       wr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq
);

    typedef enum logic [1:0] {
        REG_DIV  = 2'd0,
        REG_TIMA = 2'd1,
        REG_TMA  = 2'd2,
        REG_TAC  = 2'd3
    } reg_e;

    localparam logic [2:0] RELOAD_INIT = 3'(RELOAD_DELAY);

    logic [15:0] cnt_q,    cnt_d;
    logic [7:0]  tima_q,   tima_d;
    logic [7:0]  tma_q,    tma_d;
    logic [2:0]  tac_q,    tac_d;
    logic        tick_q,   tick_d;
    logic [2:0]  reload_q, reload_d;
    logic        irq_q,    irq_d;

    logic       wr_div, wr_tima, wr_tma, wr_tac;
    logic       tap_bit;
    logic       tick_fall;
    logic       reload_edge;
    logic [8:0] tima_inc;

    // Divider tap for the selected TIMA input frequency.
    function automatic logic tap_of(input logic [15:0] cnt, input logic [1:0] rate);
        logic bit_sel;
        case (rate)
            2'd0:    bit_sel = cnt[9];
            2'd1:    bit_sel = cnt[3];
            2'd2:    bit_sel = cnt[5];
            default: bit_sel = cnt[7];
        endcase
        return bit_sel;
    endfunction

    always_comb begin
        wr_div  = sel & wr & (addr == REG_DIV);
        wr_tima = sel & wr & (addr == REG_TIMA);
        wr_tma  = sel & wr & (addr == REG_TMA);
        wr_tac  = sel & wr & (addr == REG_TAC);
    end

    // The next tick is evaluated against the new divider value but the current TAC,
    // so a DIV write glitches TIMA on its own edge and a TAC write one edge later.
    always_comb begin
        cnt_d     = wr_div ? 16'h0000 : cnt_q + 16'd1;
        tac_d     = wr_tac ? din[2:0] : tac_q;
        tma_d     = wr_tma ? din : tma_q;
        tap_bit   = tap_of(cnt_d, tac_q[1:0]);
        tick_d    = tac_q[2] & tap_bit;
        tick_fall = tick_q & ~tick_d;
        tima_inc  = {1'b0, tima_q} + 9'd1;
    end

    always_comb begin
        reload_edge = (reload_q == 3'd1);
        tima_d      = tima_q;
        irq_d       = 1'b0;
        reload_d    = (reload_q != 3'd0) ? reload_q - 3'd1 : 3'd0;

        if (reload_edge) begin
            // The reload edge takes TMA including a same-edge TMA write; TIMA writes lose.
            tima_d = tma_d;
            irq_d  = 1'b1;
        end else if (wr_tima) begin
            tima_d   = din;
            reload_d = 3'd0;
        end else if (tick_fall) begin
            tima_d = tima_inc[7:0];
            if (tima_inc[8]) begin
                reload_d = RELOAD_INIT;
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cnt_q    <= 16'h0000;
            tima_q   <= 8'h00;
            tma_q    <= 8'h00;
            tac_q    <= 3'b000;
            tick_q   <= 1'b0;
            reload_q <= 3'd0;
            irq_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            tima_q   <= tima_d;
            tma_q    <= tma_d;
            tac_q    <= tac_d;
            tick_q   <= tick_d;
            reload_q <= reload_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        case (addr)
            REG_DIV:  dout = cnt_q[15:8];
            REG_TIMA: dout = tima_q;
            REG_TMA:  dout = tma_q;
            default:  dout = {5'b11111, tac_q};
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_dmg_timer.sv
// Directed self-checking bench for dmg_timer: vector table for register/divider
// behaviour, hand sequences for overflow reload, write races, glitches and reset.
module tb_dmg_timer;

    localparam logic [1:0] A_DIV  = 2'd0;
    localparam logic [1:0] A_TIMA = 2'd1;
    localparam logic [1:0] A_TMA  = 2'd2;
    localparam logic [1:0] A_TAC  = 2'd3;

    logic       clk = 1'b0;
    logic       res;
    logic [1:0] addr;
    logic       sel;
    logic       wr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;

    int n_checks = 0;
    int n_fail   = 0;

    dmg_timer #(.RELOAD_DELAY(4)) dut (
        .clk  (clk),
        .res  (res),
        .addr (addr),
        .sel  (sel),
        .wr   (wr),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       v_sel;
        logic       v_wr;
        logic [1:0] v_addr;
        logic [7:0] v_din;
        int         idle;
        logic [1:0] raddr;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        sel  = 1'b1;
        wr   = 1'b1;
        addr = a;
        din  = d;
        step();
        sel  = 1'b0;
        wr   = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [1:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        check(name, dout, exp);
    endtask

    task automatic irq_check(input string name, input logic exp);
        check(name, {7'd0, irq}, {7'd0, exp});
    endtask

    // Leaves TIMA at 00h right after the overflow edge (reload counter = 4).
    task automatic setup_ovf(input logic [7:0] tma);
        write_reg(A_TAC, 8'h00);
        write_reg(A_DIV, 8'h00);
        write_reg(A_TMA, tma);
        write_reg(A_TIMA, 8'hFF);
        write_reg(A_TAC, 8'h05);
        run(12);
        read_check("pre_ovf_tima", A_TIMA, 8'hFF);
        step();
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{"div_256",       1'b0, 1'b0, A_DIV,  8'h00, 256,   A_DIV,  8'h01};
        vecs[1]  = '{"div_ffff",      1'b0, 1'b0, A_DIV,  8'h00, 65279, A_DIV,  8'hFF};
        vecs[2]  = '{"div_wrap",      1'b0, 1'b0, A_DIV,  8'h00, 1,     A_DIV,  8'h00};
        vecs[3]  = '{"tac_read",      1'b1, 1'b1, A_TAC,  8'hFD, 0,     A_TAC,  8'hFD};
        vecs[4]  = '{"tima_wr0",      1'b1, 1'b1, A_TIMA, 8'h00, 0,     A_TIMA, 8'h00};
        vecs[5]  = '{"sel_gate",      1'b0, 1'b1, A_TMA,  8'h99, 0,     A_TMA,  8'h00};
        vecs[6]  = '{"div_clear",     1'b1, 1'b1, A_DIV,  8'hAB, 0,     A_DIV,  8'h00};
        vecs[7]  = '{"tima_16clk",    1'b0, 1'b0, A_DIV,  8'h00, 16,    A_TIMA, 8'h01};
        vecs[8]  = '{"tima_64clk",    1'b0, 1'b0, A_DIV,  8'h00, 48,    A_TIMA, 8'h04};
        vecs[9]  = '{"tma_write",     1'b1, 1'b1, A_TMA,  8'hC3, 0,     A_TMA,  8'hC3};
        vecs[10] = '{"tima_hold",     1'b0, 1'b0, A_DIV,  8'h00, 14,    A_TIMA, 8'h04};
        vecs[11] = '{"wr_beats_tick", 1'b1, 1'b1, A_TIMA, 8'h20, 0,     A_TIMA, 8'h20};
        vecs[12] = '{"tick_after_wr", 1'b0, 1'b0, A_DIV,  8'h00, 16,    A_TIMA, 8'h21};

        res  = 1'b1;
        sel  = 1'b0;
        wr   = 1'b0;
        addr = A_DIV;
        din  = 8'h00;
        #2;
        read_check("rst_div",  A_DIV,  8'h00);
        read_check("rst_tima", A_TIMA, 8'h00);
        read_check("rst_tma",  A_TMA,  8'h00);
        read_check("rst_tac",  A_TAC,  8'hF8);
        irq_check("rst_irq", 1'b0);
        @(negedge clk);
        res = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].v_wr) begin
                sel  = vecs[i].v_sel;
                wr   = 1'b1;
                addr = vecs[i].v_addr;
                din  = vecs[i].v_din;
                step();
                sel  = 1'b0;
                wr   = 1'b0;
            end
            run(vecs[i].idle);
            read_check(vecs[i].name, vecs[i].raddr, vecs[i].exp);
        end

        // Overflow: TIMA reads 00h for four clocks, then TMA with a one-clock irq.
        setup_ovf(8'hF0);
        for (int i = 0; i < 4; i++) begin
            read_check("ovf_window_tima", A_TIMA, 8'h00);
            irq_check("ovf_window_irq", 1'b0);
            step();
        end
        read_check("ovf_reload_tima", A_TIMA, 8'hF0);
        irq_check("ovf_reload_irq", 1'b1);
        step();
        irq_check("ovf_irq_drop", 1'b0);
        read_check("ovf_tima_hold", A_TIMA, 8'hF0);

        // TIMA write two clocks after overflow cancels the reload.
        setup_ovf(8'hF0);
        run(2);
        write_reg(A_TIMA, 8'h33);
        for (int i = 0; i < 6; i++) begin
            irq_check("cancel_irq", 1'b0);
            step();
        end
        read_check("cancel_tima", A_TIMA, 8'h33);

        // TMA write on the reload edge feeds straight into TIMA.
        setup_ovf(8'hF0);
        run(3);
        write_reg(A_TMA, 8'h77);
        read_check("tma_on_reload_tima", A_TIMA, 8'h77);
        irq_check("tma_on_reload_irq", 1'b1);
        step();
        irq_check("tma_on_reload_drop", 1'b0);

        // TIMA write on the reload edge is ignored.
        setup_ovf(8'hA5);
        run(3);
        write_reg(A_TIMA, 8'h55);
        read_check("tima_on_reload_tima", A_TIMA, 8'hA5);
        irq_check("tima_on_reload_irq", 1'b1);

        // Falling-edge glitches from a DIV write and from clearing the enable.
        write_reg(A_TAC, 8'h00);
        write_reg(A_DIV, 8'h00);
        write_reg(A_TIMA, 8'h10);
        write_reg(A_TAC, 8'h04);
        run(597);
        read_check("glitch_pre", A_TIMA, 8'h10);
        write_reg(A_DIV, 8'h00);
        read_check("glitch_div", A_TIMA, 8'h11);
        run(600);
        read_check("glitch_mid", A_TIMA, 8'h11);
        write_reg(A_TAC, 8'h00);
        read_check("glitch_tac_edge", A_TIMA, 8'h11);
        step();
        read_check("glitch_tac_next", A_TIMA, 8'h12);
        step();
        read_check("glitch_tac_once", A_TIMA, 8'h12);

        // Asynchronous reset while a reload is pending.
        setup_ovf(8'hF0);
        step();
        #2;
        res = 1'b1;
        #1;
        read_check("mid_rst_tima", A_TIMA, 8'h00);
        irq_check("mid_rst_irq", 1'b0);
        read_check("mid_rst_tma", A_TMA, 8'h00);
        @(negedge clk);
        res = 1'b0;
        for (int i = 0; i < 8; i++) begin
            irq_check("post_rst_irq", 1'b0);
            step();
        end
        read_check("post_rst_tima", A_TIMA, 8'h00);
        run(248);
        read_check("post_rst_div", A_DIV, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
